fpga_board_rst_ctrl: RTL

//  Board-level reset sequencer and input conditioner for the FPGA top wrappers.
//  - Debounces the raw reset pushbutton and NUM_IN board buttons/switches.
//  - Generates the SoC pad_reset_n. SoC reset is held while the MMCM is unlocked, while
//    the button is pressed, and for RST_HOLD_CYCLES after both conditions clear.
//  - Keeps JTAG TRST independent of the button, so the debugger survives a soft reset.
//  - Sits between board pads and the pulpissimo instance, replacing the bare ~pad_reset inversion.

---
 rtl/fpga_board_pkg.sv | 20 ++
 rtl/fpga_debounce_ch.sv | 59 +++++
 rtl/fpga_board_rst_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fpga_board_pkg.sv
// Shared types and default constants for the FPGA board reset sequencer.
package fpga_board_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2
   } rst_state_e;

   localparam int unsigned NUM_IN_DEF          = 4;
   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;
   localparam int unsigned RST_HOLD_CYCLES_DEF = 1024;

   // Width of a counter that must hold values 0..n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fpga_debounce_ch.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a stable-level debouncer.
module fpga_debounce_ch
   import fpga_board_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter logic        RESET_VAL       = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic db_o
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic [CntW-1:0]        cnt_d, cnt_q;
   logic                   db_d, db_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Any return to the current level restarts the stability count.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync_s == db_q) begin
         cnt_d = '0;
      end else if (cnt_q >= CntLast) begin
         db_d  = sync_s;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         db_q  <= RESET_VAL;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/fpga_board_rst_ctrl.sv
// Board reset sequencer: debounces buttons and pad reset, stretches SoC reset after lock.
// Optional FPGA_BOARD_EDGE_EN builds registered rise/fall pulses for the debounced buttons.
module fpga_board_rst_ctrl
   import fpga_board_pkg::*;
#(
   parameter int unsigned             NUM_IN          = NUM_IN_DEF,
   parameter int unsigned             SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned             DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned             RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
   parameter logic [NUM_IN-1:0]       RESET_LEVEL     = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pad_reset_i,
   input  logic              clk_locked_i,
   input  logic [NUM_IN-1:0] btn_raw_i,
   output logic [NUM_IN-1:0] btn_db_o,
   output logic [NUM_IN-1:0] btn_rise_o,
   output logic [NUM_IN-1:0] btn_fall_o,
   output logic              soc_rst_no,
   output logic              jtag_trst_no,
   output logic [1:0]        rst_state_o
);

   localparam int unsigned HoldW = cnt_width(RST_HOLD_CYCLES);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD_CYCLES - 1);

   logic [NUM_IN-1:0] btn_db;
   logic              rst_db;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_btn
      fpga_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_LEVEL[i])
      ) u_btn_db (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .raw_i (btn_raw_i[i]),
         .db_o  (btn_db[i])
      );
   end

   // Pad reset channel comes out of reset "pressed" so the SoC never sees a spurious release.
   fpga_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_pad_rst_db (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (pad_reset_i),
      .db_o  (rst_db)
   );

   assign btn_db_o = btn_db;

   // Lock is synchronised only; a debounce delay here would slow reaction to lock loss.
   logic [SYNC_STAGES-1:0] lk_sync_q;
   logic                   lk;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lk_sync_q <= '0;
      end else begin
         lk_sync_q <= {lk_sync_q[SYNC_STAGES-2:0], clk_locked_i};
      end
   end

   assign lk = lk_sync_q[SYNC_STAGES-1];

   rst_state_e       state_d, state_q;
   logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
   logic             fault;

   assign fault = !lk || rst_db;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_RESET: begin
            hold_cnt_d = '0;
            if (lk && !rst_db) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
            if (hold_cnt_q == HoldLast) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d    = ST_RESET;
            hold_cnt_d = '0;
         end
      endcase
      // Fault overrides everything, including a hold that would complete this cycle.
      if (fault) begin
         state_d    = ST_RESET;
         hold_cnt_d = '0;
      end
   end

   logic soc_rst_nq, jtag_trst_nq;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_RESET;
         hold_cnt_q   <= '0;
         soc_rst_nq   <= 1'b0;
         jtag_trst_nq <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         soc_rst_nq   <= (state_d == ST_RUN);
         jtag_trst_nq <= lk;
      end
   end

   assign soc_rst_no   = soc_rst_nq;
   assign jtag_trst_no = jtag_trst_nq;
   assign rst_state_o  = state_q;

`ifdef FPGA_BOARD_EDGE_EN
   logic [NUM_IN-1:0] btn_db_q, rise_q, fall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btn_db_q <= RESET_LEVEL;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         btn_db_q <= btn_db;
         rise_q   <= btn_db & ~btn_db_q;
         fall_q   <= ~btn_db & btn_db_q;
      end
   end

   assign btn_rise_o = rise_q;
   assign btn_fall_o = fall_q;
`else
   assign btn_rise_o = '0;
   assign btn_fall_o = '0;
`endif

endmodule
